// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector.
// Optional match counter is built only when SEQ_DET_CNT_EN is defined.
package seq_det_pkg;

   // Overlap mode encodings for cfg_overlap_i
   localparam logic OVL_ON  = 1'b1;
   localparam logic OVL_OFF = 1'b0;

   // Default geometry
   localparam int          PAT_LEN_DEF = 8;
   localparam int          CNT_W_DEF   = 8;
   localparam logic [7:0]  RST_PAT_DEF = 8'b0110_1010;

   // Fill counter must hold 0..16
   localparam int FILL_W = 5;

   // Moore detector state
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_MATCH = 1'b1
   } det_state_e;

   // Saturating increment of the history fill level
   function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] fill,
                                                     input logic [FILL_W-1:0] limit);
      if (fill >= limit) begin
         return limit;
      end
      return fill + 5'd1;
   endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module seq_det_sat_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear first, then increment unless already all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// Run-time programmable Moore serial-pattern detector.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise
// match_cnt_o is tied to zero and cnt_clr_i is ignored.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  ST_IDLE  | no match completed on the previous edge
//  ST_MATCH | last accepted sample completed a match (flag)
module seq_detector
   import seq_det_pkg::*;
#(
   parameter int                 PAT_LEN = PAT_LEN_DEF,
   parameter int                 CNT_W   = CNT_W_DEF,
   parameter logic [PAT_LEN-1:0] RST_PAT = PAT_LEN'(RST_PAT_DEF)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               din_i,
   input  logic               din_valid_i,
   input  logic               cfg_load_i,
   input  logic [PAT_LEN-1:0] cfg_pattern_i,
   input  logic               cfg_overlap_i,
   input  logic               cnt_clr_i,
   output logic               flag_o,
   output logic [CNT_W-1:0]   match_cnt_o
);

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

   det_state_e         state_q, state_d;
   logic [PAT_LEN-1:0] hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [PAT_LEN-1:0] pattern_q, pattern_d;
   logic               overlap_q, overlap_d;

   logic [PAT_LEN-1:0] hist_shift;
   logic [FILL_W-1:0]  fill_inc;
   logic               match;

   // The oldest history bit is shifted out before it is ever compared
   logic hist_msb_unused;
   assign hist_msb_unused = hist_q[PAT_LEN-1];

   // State register: Moore state plus history, fill and configuration
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         hist_q    <= '0;
         fill_q    <= '0;
         pattern_q <= RST_PAT;
         overlap_q <= OVL_ON;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         pattern_q <= pattern_d;
         overlap_q <= overlap_d;
      end
   end

   // Next-state: config load wins over a sample; a match in
   // non-overlap mode restarts the history from empty
   always_comb begin
      state_d    = ST_IDLE;
      hist_d     = hist_q;
      fill_d     = fill_q;
      pattern_d  = pattern_q;
      overlap_d  = overlap_q;
      match      = 1'b0;
      hist_shift = {hist_q[PAT_LEN-2:0], din_i};
      fill_inc   = fill_sat_inc(fill_q, FILL_MAX);

      if (cfg_load_i) begin
         pattern_d = cfg_pattern_i;
         overlap_d = cfg_overlap_i;
         hist_d    = '0;
         fill_d    = '0;
      end else if (din_valid_i) begin
         match = (fill_inc == FILL_MAX) && (hist_shift == pattern_q);
         if (match && (overlap_q == OVL_OFF)) begin
            hist_d = '0;
            fill_d = '0;
         end else begin
            hist_d = hist_shift;
            fill_d = fill_inc;
         end
         if (match) begin
            state_d = ST_MATCH;
         end
      end
   end

   // Moore output: flag straight from the state register
   always_comb begin
      flag_o = (state_q == ST_MATCH);
   end

`ifdef SEQ_DET_CNT_EN
   seq_det_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_sat_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (match),
      .clr_i  (cnt_clr_i),
      .cnt_o  (match_cnt_o)
   );
`else
   logic cnt_clr_unused;
   assign cnt_clr_unused = cnt_clr_i;
   assign match_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: one 8-bit default instance and one
// 4-bit instance with a 2-bit counter. Count expectations follow the build.
module tb_seq_detector;

`ifdef SEQ_DET_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       d8_din, d8_vld, d8_load, d8_ovl, d8_clr, d8_flag;
   logic [7:0] d8_pat, d8_cnt;
   logic       d4_din, d4_vld, d4_load, d4_ovl, d4_clr, d4_flag;
   logic [3:0] d4_pat;
   logic [1:0] d4_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0] pat8 = 8'b0110_1010;
   logic [6:0] str4 = 7'b0101010;

   seq_detector u_dut8 (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .din_i         (d8_din),
      .din_valid_i   (d8_vld),
      .cfg_load_i    (d8_load),
      .cfg_pattern_i (d8_pat),
      .cfg_overlap_i (d8_ovl),
      .cnt_clr_i     (d8_clr),
      .flag_o        (d8_flag),
      .match_cnt_o   (d8_cnt)
   );

   seq_detector #(
      .PAT_LEN (4),
      .CNT_W   (2),
      .RST_PAT (4'b0101)
   ) u_dut4 (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .din_i         (d4_din),
      .din_valid_i   (d4_vld),
      .cfg_load_i    (d4_load),
      .cfg_pattern_i (d4_pat),
      .cfg_overlap_i (d4_ovl),
      .cnt_clr_i     (d4_clr),
      .flag_o        (d4_flag),
      .match_cnt_o   (d4_cnt)
   );

   function automatic int ecnt(input int n);
      return CNT_ON ? n : 0;
   endfunction

   task automatic ck8(input string tag, input logic ef, input int ec);
      logic [7:0] exp_cnt;
      exp_cnt = 8'(ecnt(ec));
      checks++;
      assert (d8_flag === ef) else begin
         errors++;
         $error("FAIL %s flag8 observed=%b expected=%b", tag, d8_flag, ef);
      end
      checks++;
      assert (d8_cnt === exp_cnt) else begin
         errors++;
         $error("FAIL %s cnt8 observed=%0d expected=%0d", tag, d8_cnt, exp_cnt);
      end
   endtask

   task automatic ck4(input string tag, input logic ef, input int ec);
      logic [1:0] exp_cnt;
      exp_cnt = 2'(ecnt(ec));
      checks++;
      assert (d4_flag === ef) else begin
         errors++;
         $error("FAIL %s flag4 observed=%b expected=%b", tag, d4_flag, ef);
      end
      checks++;
      assert (d4_cnt === exp_cnt) else begin
         errors++;
         $error("FAIL %s cnt4 observed=%0d expected=%0d", tag, d4_cnt, exp_cnt);
      end
   endtask

   task automatic t8(input logic b, input logic v);
      d8_din = b;
      d8_vld = v;
      @(posedge clk);
      #1;
      d8_vld = 1'b0;
   endtask

   task automatic t4(input logic b, input logic v);
      d4_din = b;
      d4_vld = v;
      @(posedge clk);
      #1;
      d4_vld = 1'b0;
   endtask

   task automatic ld8(input logic [7:0] p, input logic o, input logic b, input logic v);
      d8_load = 1'b1;
      d8_pat  = p;
      d8_ovl  = o;
      d8_din  = b;
      d8_vld  = v;
      @(posedge clk);
      #1;
      d8_load = 1'b0;
      d8_vld  = 1'b0;
   endtask

   task automatic ld4(input logic [3:0] p, input logic o);
      d4_load = 1'b1;
      d4_pat  = p;
      d4_ovl  = o;
      d4_vld  = 1'b0;
      @(posedge clk);
      #1;
      d4_load = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      d8_din  = 1'b0; d8_vld = 1'b0; d8_load = 1'b0; d8_ovl = 1'b0;
      d8_clr  = 1'b0; d8_pat = '0;
      d4_din  = 1'b0; d4_vld = 1'b0; d4_load = 1'b0; d4_ovl = 1'b0;
      d4_clr  = 1'b0; d4_pat = '0;

      // Reset values
      #3;
      ck8("reset", 1'b0, 0);
      ck4("reset", 1'b0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Default pattern, overlap on: flag only after bit 8
      for (int i = 0; i < 8; i++) begin
         t8(pat8[7-i], 1'b1);
         ck8("dflt_bit", (i == 7), (i == 7) ? 1 : 0);
      end
      t8(1'b0, 1'b0);
      ck8("dflt_idle", 1'b0, 1);

      // 4-bit 0101 overlapping on 0101010: flags after bits 4 and 6
      ld4(4'b0101, 1'b1);
      ck4("load4_ovl", 1'b0, 0);
      for (int i = 0; i < 7; i++) begin
         t4(str4[6-i], 1'b1);
         ck4("ovl4_bit", (i == 3 || i == 5), (i < 3) ? 0 : ((i < 5) ? 1 : 2));
      end
      t4(1'b0, 1'b0);
      ck4("ovl4_idle", 1'b0, 2);

      // Non-overlapping: cfg_load keeps count, clear, then flag after bit 4 only
      ld4(4'b0101, 1'b0);
      ck4("load4_keeps_cnt", 1'b0, 2);
      d4_clr = 1'b1;
      t4(1'b0, 1'b0);
      d4_clr = 1'b0;
      ck4("clr4", 1'b0, 0);
      for (int i = 0; i < 7; i++) begin
         t4(str4[6-i], 1'b1);
         ck4("novl4_bit", (i == 3), (i < 3) ? 0 : 1);
      end

      // Idle gap of 3 cycles inside a matching pattern
      for (int i = 0; i < 4; i++) begin
         t8(pat8[7-i], 1'b1);
         ck8("gap_head", 1'b0, 1);
      end
      for (int i = 0; i < 3; i++) begin
         t8(1'b1, 1'b0);
         ck8("gap_idle", 1'b0, 1);
      end
      for (int i = 4; i < 8; i++) begin
         t8(pat8[7-i], 1'b1);
         ck8("gap_tail", (i == 7), (i == 7) ? 2 : 1);
      end

      // cfg_load on the completing bit discards the sample and empties history
      for (int i = 0; i < 7; i++) begin
         t8(pat8[7-i], 1'b1);
         ck8("ld_pre", 1'b0, 2);
      end
      ld8(8'b0000_0001, 1'b1, 1'b0, 1'b1);
      ck8("ld_vs_match", 1'b0, 2);
      t8(1'b1, 1'b1);
      ck8("ld_fill_clear", 1'b0, 2);
      for (int i = 0; i < 7; i++) begin
         t8(1'b0, 1'b1);
         ck8("ld_zeros", 1'b0, 2);
      end
      t8(1'b1, 1'b1);
      ck8("ld_new_match", 1'b1, 3);

      // Reset mid-pattern after 5 of 8 bits
      for (int i = 0; i < 5; i++) begin
         t8(pat8[7-i], 1'b1);
         ck8("rst_pre", 1'b0, 3);
      end
      rst_n = 1'b0;
      #2;
      ck8("rst_mid", 1'b0, 0);
      ck4("rst_mid", 1'b0, 0);
      #2;
      rst_n = 1'b1;
      for (int i = 5; i < 8; i++) begin
         t8(pat8[7-i], 1'b1);
         ck8("rst_rest", 1'b0, 0);
      end
      for (int i = 0; i < 8; i++) begin
         t8(pat8[7-i], 1'b1);
         ck8("rst_full", (i == 7), (i == 7) ? 1 : 0);
      end

      // 2-bit counter saturates at 3; clear beats a simultaneous match
      ld4(4'b0101, 1'b1);
      ck4("sat_load", 1'b0, 0);
      for (int i = 0; i < 14; i++) begin
         int nm;
         nm = (i >= 3) ? (i - 1) / 2 : 0;
         d4_clr = (i == 13);
         t4(logic'(i % 2), 1'b1);
         ck4("sat_bit", (i >= 3 && (i % 2) == 1), (i == 13) ? 0 : ((nm > 3) ? 3 : nm));
      end
      d4_clr = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
